// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: word width and ALU op encodings.
package datapath_pkg;

    localparam int unsigned WordW = 32;

    localparam logic [4:0] OpAdd  = 5'b00000;
    localparam logic [4:0] OpSub  = 5'b00001;
    localparam logic [4:0] OpAnd  = 5'b00010;
    localparam logic [4:0] OpOr   = 5'b00011;
    localparam logic [4:0] OpNeg  = 5'b00100;
    localparam logic [4:0] OpMul  = 5'b00101;
    localparam logic [4:0] OpDiv  = 5'b00110;
    localparam logic [4:0] OpNot  = 5'b00111;
    localparam logic [4:0] OpShr  = 5'b01000;
    localparam logic [4:0] OpShra = 5'b01001;
    localparam logic [4:0] OpShl  = 5'b01010;
    localparam logic [4:0] OpRor  = 5'b01011;
    localparam logic [4:0] OpRol  = 5'b01100;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
module alu
    import datapath_pkg::*;
(
    input  logic [WordW-1:0]   A,
    input  logic [WordW-1:0]   B,
    input  logic [4:0]         ops,
    output logic [2*WordW-1:0] C
);

    logic [4:0]                sh;
    logic signed [2*WordW-1:0] prod;
    logic [2*WordW-1:0]        dbl;
    logic [2*WordW-1:0]        ror_w;
    logic [2*WordW-1:0]        rol_w;
    logic [WordW-1:0]          quo;
    logic [WordW-1:0]          rem;

    assign sh    = B[4:0];
    assign prod  = $signed({{WordW{A[WordW-1]}}, A}) * $signed({{WordW{B[WordW-1]}}, B});
    // Rotates come from shifting a doubled copy of A.
    assign dbl   = {A, A};
    assign ror_w = dbl >> sh;
    assign rol_w = dbl << sh;
    // Divide by zero is forced to zero rather than left to the operator.
    assign quo   = (B == '0) ? '0 : WordW'($signed(A) / $signed(B));
    assign rem   = (B == '0) ? '0 : WordW'($signed(A) % $signed(B));

    // Operation decode; single-word results are zero-extended into the upper half.
    always_comb begin
        C = '0;
        unique case (ops)
            OpAdd:   C[WordW-1:0] = A + B;
            OpSub:   C[WordW-1:0] = A - B;
            OpAnd:   C[WordW-1:0] = A & B;
            OpOr:    C[WordW-1:0] = A | B;
            OpNeg:   C[WordW-1:0] = '0 - B;
            OpMul:   C = prod;
            OpDiv:   C = {rem, quo};
            OpNot:   C[WordW-1:0] = ~B;
            OpShr:   C[WordW-1:0] = A >> sh;
            OpShra:  C[WordW-1:0] = $signed(A) >>> sh;
            OpShl:   C[WordW-1:0] = A << sh;
            OpRor:   C[WordW-1:0] = ror_w[WordW-1:0];
            OpRol:   C[WordW-1:0] = rol_w[2*WordW-1:WordW];
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, special registers, bus mux, MDR mux, ALU.
module data_path
    import datapath_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [WordW-1:0] Mdatain,
    input  logic [4:0]       ops,
    input  logic             RAout, R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout, MDRout,
    input  logic             PORTout,
    input  logic             RAin, R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             RYin, RZin, PCin, IRin, HIin, LOin, MDRin, PORTin,
    input  logic             Read,
    output logic [WordW-1:0] BusMuxOut
);

    logic [15:0]          r_out;
    logic [15:0]          r_in;
    logic [WordW-1:0]     r_q [16];
    logic [WordW-1:0]     ra_q, y_q, pc_q, ir_q, hi_q, lo_q, mdr_q, port_q;
    logic [2*WordW-1:0]   z_q;
    logic [2*WordW-1:0]   alu_c;
    logic [WordW-1:0]     mdr_d;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // Priority bus mux: written lowest priority first so the last match (R0) wins.
    always_comb begin
        BusMuxOut = '0;
        if (RYout)   BusMuxOut = y_q;
        if (IRout)   BusMuxOut = ir_q;
        if (PORTout) BusMuxOut = port_q;
        if (MDRout)  BusMuxOut = mdr_q;
        if (PCout)   BusMuxOut = pc_q;
        if (RZLOout) BusMuxOut = z_q[WordW-1:0];
        if (RZHIout) BusMuxOut = z_q[2*WordW-1:WordW];
        if (LOout)   BusMuxOut = lo_q;
        if (HIout)   BusMuxOut = hi_q;
        if (RAout)   BusMuxOut = ra_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) BusMuxOut = r_q[i];
        end
    end

    // MDR input mux: memory data on a read, otherwise the bus.
    assign mdr_d = Read ? Mdatain : BusMuxOut;

    alu u_alu (
        .A   (y_q),
        .B   (BusMuxOut),
        .ops (ops),
        .C   (alu_c)
    );

    // Register loads on rising edge; clear=0 zeroes everything asynchronously.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            ra_q   <= '0;
            y_q    <= '0;
            z_q    <= '0;
            pc_q   <= '0;
            ir_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            mdr_q  <= '0;
            port_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_in[i]) r_q[i] <= BusMuxOut;
            end
            if (RAin)   ra_q   <= BusMuxOut;
            if (RYin)   y_q    <= BusMuxOut;
            if (RZin)   z_q    <= alu_c;
            if (PCin)   pc_q   <= BusMuxOut;
            if (IRin)   ir_q   <= BusMuxOut;
            if (HIin)   hi_q   <= BusMuxOut;
            if (LOin)   lo_q   <= BusMuxOut;
            if (MDRin)  mdr_q  <= mdr_d;
            if (PORTin) port_q <= BusMuxOut;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: register transfers, ALU ops, MDR mux, async clear.
module tb_data_path;

    // Source (out) strobe indices
    localparam int O_RA = 16, O_HI = 17, O_LO = 18, O_ZHI = 19, O_ZLO = 20, O_PC = 21;
    localparam int O_MDR = 22, O_PORT = 23, O_IR = 24, O_Y = 25;
    // Destination (in) strobe indices
    localparam int I_RA = 16, I_HI = 17, I_LO = 18, I_Z = 19, I_PC = 20;
    localparam int I_MDR = 21, I_PORT = 22, I_IR = 23, I_Y = 24;

    logic        clock;
    logic        clear;
    logic [31:0] Mdatain;
    logic [4:0]  ops;
    logic        Read;
    logic [25:0] outs;
    logic [24:0] ins;
    logic [31:0] BusMuxOut;

    int n_cmp;
    int n_err;

    data_path dut (
        .clock     (clock),
        .clear     (clear),
        .Mdatain   (Mdatain),
        .ops       (ops),
        .RAout     (outs[O_RA]),
        .R0out     (outs[0]),  .R1out  (outs[1]),  .R2out  (outs[2]),  .R3out  (outs[3]),
        .R4out     (outs[4]),  .R5out  (outs[5]),  .R6out  (outs[6]),  .R7out  (outs[7]),
        .R8out     (outs[8]),  .R9out  (outs[9]),  .R10out (outs[10]), .R11out (outs[11]),
        .R12out    (outs[12]), .R13out (outs[13]), .R14out (outs[14]), .R15out (outs[15]),
        .RYout     (outs[O_Y]),
        .RZHIout   (outs[O_ZHI]),
        .RZLOout   (outs[O_ZLO]),
        .PCout     (outs[O_PC]),
        .IRout     (outs[O_IR]),
        .HIout     (outs[O_HI]),
        .LOout     (outs[O_LO]),
        .MDRout    (outs[O_MDR]),
        .PORTout   (outs[O_PORT]),
        .RAin      (ins[I_RA]),
        .R0in      (ins[0]),  .R1in  (ins[1]),  .R2in  (ins[2]),  .R3in  (ins[3]),
        .R4in      (ins[4]),  .R5in  (ins[5]),  .R6in  (ins[6]),  .R7in  (ins[7]),
        .R8in      (ins[8]),  .R9in  (ins[9]),  .R10in (ins[10]), .R11in (ins[11]),
        .R12in     (ins[12]), .R13in (ins[13]), .R14in (ins[14]), .R15in (ins[15]),
        .RYin      (ins[I_Y]),
        .RZin      (ins[I_Z]),
        .PCin      (ins[I_PC]),
        .IRin      (ins[I_IR]),
        .HIin      (ins[I_HI]),
        .LOin      (ins[I_LO]),
        .MDRin     (ins[I_MDR]),
        .PORTin    (ins[I_PORT]),
        .Read      (Read),
        .BusMuxOut (BusMuxOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one source onto the bus and compare what appears.
    task automatic rd(input int src, input logic [31:0] exp, input string tag);
        outs[src] = 1'b1;
        #1;
        check(tag, BusMuxOut, exp);
        outs[src] = 1'b0;
    endtask

    task automatic xfer(input int src, input int dst);
        outs[src] = 1'b1;
        ins[dst]  = 1'b1;
        tick();
        outs[src] = 1'b0;
        ins[dst]  = 1'b0;
    endtask

    // Bring a constant in through MDR and move it to dst.
    task automatic load(input int dst, input logic [31:0] val);
        Read       = 1'b1;
        Mdatain    = val;
        ins[I_MDR] = 1'b1;
        tick();
        ins[I_MDR] = 1'b0;
        xfer(O_MDR, dst);
    endtask

    task automatic alu_op(input logic [4:0] op, input int bsrc, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input string tag);
        ops = op;
        xfer(bsrc, I_Z);
        rd(O_ZLO, exp_lo, {tag, "_lo"});
        rd(O_ZHI, exp_hi, {tag, "_hi"});
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        outs    = '0;
        ins     = '0;
        Read    = 1'b0;
        Mdatain = '0;
        ops     = '0;
        clear   = 1'b0;
        tick();
        tick();
        check("reset_bus_idle", BusMuxOut, 32'h0);
        rd(1, 32'h0, "reset_r1");
        rd(O_ZHI, 32'h0, "reset_zhi");
        @(negedge clock);
        clear = 1'b1;

        // 1 MUL: -3 * 4
        load(I_Y, 32'hFFFF_FFFD);
        load(2, 32'h0000_0004);
        ops = 5'b00101;
        xfer(2, I_Z);
        xfer(O_ZLO, 1);
        xfer(O_ZHI, I_HI);
        rd(1, 32'hFFFF_FFF4, "mul_r1");
        rd(O_HI, 32'hFFFF_FFFF, "mul_hi");

        // 2 ADD and wrap
        load(I_Y, 32'd5);
        load(3, 32'd7);
        alu_op(5'b00000, 3, 32'd12, 32'd0, "add");
        load(I_Y, 32'hFFFF_FFFF);
        load(3, 32'd1);
        alu_op(5'b00000, 3, 32'd0, 32'd0, "add_wrap");

        // 3 DIV: -7 / 2 and divide by zero
        load(I_Y, 32'hFFFF_FFF9);
        load(4, 32'd2);
        alu_op(5'b00110, 4, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div");
        load(4, 32'd0);
        alu_op(5'b00110, 4, 32'd0, 32'd0, "div0");

        // 4 Shifts, rotates and logic ops with Y=0x80000001, B=1
        load(I_Y, 32'h8000_0001);
        load(6, 32'd1);
        alu_op(5'b01001, 6, 32'hC000_0000, 32'd0, "shra");
        alu_op(5'b01000, 6, 32'h4000_0000, 32'd0, "shr");
        alu_op(5'b01100, 6, 32'h0000_0003, 32'd0, "rol");
        alu_op(5'b01011, 6, 32'hC000_0000, 32'd0, "ror");
        alu_op(5'b01010, 6, 32'h0000_0002, 32'd0, "shl");
        alu_op(5'b00001, 6, 32'h8000_0000, 32'd0, "sub");
        alu_op(5'b00010, 6, 32'h0000_0001, 32'd0, "and");
        alu_op(5'b00011, 6, 32'h8000_0001, 32'd0, "or");
        alu_op(5'b00100, 6, 32'hFFFF_FFFF, 32'd0, "neg");
        alu_op(5'b00111, 6, 32'hFFFF_FFFE, 32'd0, "not");
        alu_op(5'b01101, 6, 32'd0, 32'd0, "bad_op");

        // Bus priority: R6 beats RA, RA beats PC
        load(I_RA, 32'h1111_2222);
        load(I_PC, 32'h3333_4444);
        outs[6] = 1'b1; outs[O_RA] = 1'b1; outs[O_PC] = 1'b1;
        #1;
        check("prio_r6", BusMuxOut, 32'd1);
        outs[6] = 1'b0;
        #1;
        check("prio_ra", BusMuxOut, 32'h1111_2222);
        outs = '0;

        // Self-load keeps the value
        xfer(O_PC, I_PC);
        rd(O_PC, 32'h3333_4444, "self_load_pc");

        // 5 MDR mux
        load(5, 32'hA5A5_A5A5);
        Read = 1'b0;
        xfer(5, I_MDR);
        rd(O_MDR, 32'hA5A5_A5A5, "mdr_from_bus");
        Read       = 1'b1;
        Mdatain    = 32'h1234_5678;
        ins[I_MDR] = 1'b1;
        tick();
        ins[I_MDR] = 1'b0;
        rd(O_MDR, 32'h1234_5678, "mdr_from_mem");
        #1;
        check("bus_idle", BusMuxOut, 32'h0);

        // 6 Async clear between edges; no loads while held
        @(negedge clock);
        #1;
        clear = 1'b0;
        rd(5, 32'h0, "clr_r5_async");
        Mdatain    = 32'hDEAD_BEEF;
        ins[I_MDR] = 1'b1;
        tick();
        ins[I_MDR] = 1'b0;
        rd(O_MDR, 32'h0, "clr_mdr_held");
        rd(O_HI, 32'h0, "clr_hi");
        rd(O_Y, 32'h0, "clr_y");
        rd(O_PC, 32'h0, "clr_pc");
        rd(O_RA, 32'h0, "clr_ra");
        rd(O_ZLO, 32'h0, "clr_zlo");
        rd(1, 32'h0, "clr_r1");
        @(negedge clock);
        clear = 1'b1;
        load(7, 32'h0BAD_F00D);
        rd(7, 32'h0BAD_F00D, "post_clear_load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
